axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares the single downstream AXI4 read channel (AR + R) between two burst read requesters: requester 0 is the icache line-refill port, requester 1 is the dcache refill port.
- Performs round-robin arbitration and locks the grant for one whole burst.
- Muxes the AR signals out and routes the R beats back to the granted requester.
- Checks that each burst's length matches its arlen and flags any violation.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, read data width
- LEN_W, 8, arlen width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- mN_araddr  in  ADDR_W  requester N burst address (N = 0, 1, all mN_ ports replicated)
- mN_arvalid  in  1  requester N address valid
- mN_arburst  in  2  burst type
- mN_arlen  in  LEN_W  beats minus 1
- mN_arsize  in  3  beat size
- mN_arready  out  1  address accepted
- mN_rdata  out  DATA_W  read beat data
- mN_rresp  out  2  beat response
- mN_rvalid  out  1  beat valid
- mN_rlast  out  1  last beat
- mN_rready  in  1  requester N ready for beat
- s_araddr, s_arvalid, s_arburst, s_arlen, s_arsize  out  as mN  downstream AR channel
- s_arready  in  1  downstream address ready
- s_rdata, s_rresp, s_rvalid, s_rlast  in  as mN  downstream R channel
- s_rready  out  1  downstream beat ready
- grant  out  2  one-hot owner; 00 when idle
- busy  out  1  high in ST_AR and ST_R
- len_err  out  1  sticky burst-length error

Behaviour:
- FSM states: ST_IDLE, ST_AR, ST_R.
  - Register: last_grant (1 bit).
  - Register: beat counter (LEN_W bits).
  - Register: latched arlen.
- Reset (rst=0, async): state ST_IDLE, grant 00, last_grant=1 (so requester 0 wins the first tie), counter 0, len_err 0.
  - All outputs are 0 during and after reset.
- ST_IDLE:
  - If exactly one mN_arvalid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - grant is registered; the FSM enters ST_AR on the next edge, giving a 1-cycle arbitration latency.
  - No mN_arready is asserted in ST_IDLE.
- ST_AR:
  - s_ar* = granted requester's AR fields; s_arvalid = granted mN_arvalid.
  - granted mN_arready = s_arready; the other requester's arready = 0.
  - On s_arvalid & s_arready: latch s_arlen, clear the counter, enter ST_R.
  - If the granted arvalid drops before the handshake: stay in ST_AR with s_arvalid low and no fault.
- ST_R:
  - Granted mN_rdata/rresp/rvalid/rlast = s_r*; s_rready = granted mN_rready.
  - Non-granted requester sees rvalid = 0 and rlast = 0.
  - Each beat (s_rvalid & s_rready) increments the counter.
  - On a beat with s_rlast:
    - Set len_err if counter != latched arlen.
    - Enter ST_IDLE, set last_grant to the granted index, clear grant.
  - On a beat without s_rlast where counter == latched arlen: set len_err and remain in ST_R until rlast arrives.
- Back-pressure: s_rready low holds the beat; no counter change.
- The rlast-to-next-grant bubble is 1 cycle (ST_IDLE re-arbitrates); no AR is issued while a burst is in flight, so there is no outstanding-transaction overlap.
- s_ar* fields default to 0 outside ST_AR; s_rready is 0 outside ST_R.
- Counter arithmetic is unsigned LEN_W bits; it saturates at all-ones and does not wrap.
- Reset mid-burst: immediate return to ST_IDLE with all handshake outputs low; the downstream slave is reset by the same rst.

Decomposition:
- Shared package (axi_pkg): AXI_BURST_INCR=2'b01, RESP_OKAY=2'b00, ADDR_W/DATA_W/LEN_W defaults, FSM state encoding.
- One natural sub-module: rr_arb2 (2-way round-robin picker: inputs req[1:0] and last_grant; output one-hot pick).
- AR/R muxing stays in the top level.

Test Plan:
- Single request:
  - Stimulus: m0 requests 0x8000_0040, arlen=7, slave returns 8 beats 0x1..0x8.
  - Required: grant=01 one cycle after arvalid; s_araddr=0x8000_0040; m0 receives the 8 beats with rlast on beat 8; m1_rvalid stays 0; len_err=0.
- Simultaneous requests after reset:
  - Stimulus: m0 and m1 assert arvalid in the same cycle.
  - Required: m0 served first; m1 granted in the cycle after m0's rlast+1; third tie goes to m0.
- Starvation check:
  - Stimulus: m0 re-requests immediately after each burst while m1 holds arvalid.
  - Required: grants alternate 01, 10, 01.
- Back-pressure:
  - Stimulus: m1 drops rready for 3 cycles mid-burst.
  - Required: s_rready=0 for those cycles, the beat is held, the counter is unchanged, and all 8 beats are delivered in order.
- Length error:
  - Stimulus: arlen=7, slave asserts rlast on beat 5; second case slave sends 9 beats.
  - Required: len_err=1 on beat 5 and the FSM returns to IDLE; second case len_err=1 at beat 9, IDLE after rlast.
- Async reset:
  - Stimulus: rst=0 asserted between clock edges at beat 3.
  - Required: grant=00, busy=0, all valid/ready outputs 0 immediately; after release, a new m0 request is granted normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read arbiter: AXI encodings, default
// widths and the arbiter FSM state encoding.
package axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY      = 2'b00;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 64;
   localparam int AXI_LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone request always wins; on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] pick
);

   // One-hot pick from the request pair and the previous winner
   always_comb begin
      pick = 2'b00;
      if (req[0] && (!req[1] || last_grant)) begin
         pick = 2'b01;
      end else if (req[1]) begin
         pick = 2'b10;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one downstream AXI4 read channel between the icache refill port
// (requester 0) and the dcache refill port (requester 1). The grant is held
// for a whole burst, and every burst's beat count is checked against arlen.
module axi_rd_arbiter
   import axi_pkg::*;
#(
   parameter int ADDR_W = AXI_ADDR_W,
   parameter int DATA_W = AXI_DATA_W,
   parameter int LEN_W  = AXI_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   // requester 0
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic              m0_arvalid,
   input  logic [1:0]        m0_arburst,
   input  logic [LEN_W-1:0]  m0_arlen,
   input  logic [2:0]        m0_arsize,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rvalid,
   output logic              m0_rlast,
   input  logic              m0_rready,
   // requester 1
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic              m1_arvalid,
   input  logic [1:0]        m1_arburst,
   input  logic [LEN_W-1:0]  m1_arlen,
   input  logic [2:0]        m1_arsize,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rvalid,
   output logic              m1_rlast,
   input  logic              m1_rready,
   // downstream
   output logic [ADDR_W-1:0] s_araddr,
   output logic              s_arvalid,
   output logic [1:0]        s_arburst,
   output logic [LEN_W-1:0]  s_arlen,
   output logic [2:0]        s_arsize,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rvalid,
   input  logic              s_rlast,
   output logic              s_rready,
   // status
   output logic [1:0]        grant,
   output logic              busy,
   output logic              len_err
);

   arb_state_e       state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             last_grant_q, last_grant_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             len_err_q, len_err_d;

   logic [1:0]       pick;
   logic             gidx;
   logic             ar_hs;
   logic             r_beat;

   // Beat counter saturates instead of wrapping so an overlong burst cannot
   // alias back onto a legal count.
   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
      logic [LEN_W-1:0] one;
      one = {{(LEN_W-1){1'b0}}, 1'b1};
      return (&v) ? v : v + one;
   endfunction

   rr_arb2 u_rr_arb2 (
      .req        ({m1_arvalid, m0_arvalid}),
      .last_grant (last_grant_q),
      .pick       (pick)
   );

   assign gidx    = grant_q[1];
   assign ar_hs   = (state_q == ST_AR) && s_arvalid && s_arready;
   assign r_beat  = (state_q == ST_R) && s_rvalid && s_rready;

   assign grant   = grant_q;
   assign busy    = (state_q != ST_IDLE);
   assign len_err = len_err_q;

   // State and bookkeeping registers; last_grant resets to 1 so requester 0
   // wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         len_q        <= '0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         len_err_q    <= len_err_d;
      end
   end

   // Next state: arbitrate in IDLE, wait for the AR handshake, then count
   // beats until rlast and compare against the latched arlen.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      len_err_d    = len_err_q;
      case (state_q)
         ST_IDLE: begin
            if (|pick) begin
               grant_d = pick;
               state_d = ST_AR;
            end
         end
         ST_AR: begin
            if (ar_hs) begin
               len_d   = s_arlen;
               cnt_d   = '0;
               state_d = ST_R;
            end
         end
         ST_R: begin
            if (r_beat) begin
               cnt_d = sat_inc(cnt_q);
               if (s_rlast) begin
                  if (cnt_q != len_q) begin
                     len_err_d = 1'b1;
                  end
                  last_grant_d = gidx;
                  grant_d      = 2'b00;
                  state_d      = ST_IDLE;
               end else if (cnt_q == len_q) begin
                  // Expected last beat arrived without rlast; keep routing
                  // until the slave ends the burst.
                  len_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // Channel muxing: AR fields from the owner in ST_AR, R beats to the owner
   // in ST_R, everything else held at zero.
   always_comb begin
      s_araddr   = '0;
      s_arvalid  = 1'b0;
      s_arburst  = 2'b00;
      s_arlen    = '0;
      s_arsize   = 3'b000;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = RESP_OKAY;
      m0_rvalid  = 1'b0;
      m0_rlast   = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = RESP_OKAY;
      m1_rvalid  = 1'b0;
      m1_rlast   = 1'b0;
      case (state_q)
         ST_AR: begin
            if (gidx) begin
               s_araddr   = m1_araddr;
               s_arvalid  = m1_arvalid;
               s_arburst  = m1_arburst;
               s_arlen    = m1_arlen;
               s_arsize   = m1_arsize;
               m1_arready = s_arready;
            end else begin
               s_araddr   = m0_araddr;
               s_arvalid  = m0_arvalid;
               s_arburst  = m0_arburst;
               s_arlen    = m0_arlen;
               s_arsize   = m0_arsize;
               m0_arready = s_arready;
            end
         end
         ST_R: begin
            if (gidx) begin
               s_rready  = m1_rready;
               m1_rdata  = s_rdata;
               m1_rresp  = s_rresp;
               m1_rvalid = s_rvalid;
               m1_rlast  = s_rlast;
            end else begin
               s_rready  = m0_rready;
               m0_rdata  = s_rdata;
               m0_rresp  = s_rresp;
               m0_rvalid = s_rvalid;
               m0_rlast  = s_rlast;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all continuously compared to a transaction-level
// model of the arbiter.
module tb_axi_rd_arbiter;
   import axi_pkg::*;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int LW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [1:0][AW-1:0] araddr;
   logic [1:0]         arvalid;
   logic [1:0][1:0]    arburst;
   logic [1:0][LW-1:0] arlen;
   logic [1:0][2:0]    arsize;
   logic [1:0]         arready;
   logic [1:0][DW-1:0] rdata;
   logic [1:0][1:0]    rresp;
   logic [1:0]         rvalid, rlast, rready;

   logic [AW-1:0] s_araddr;
   logic          s_arvalid;
   logic [1:0]    s_arburst;
   logic [LW-1:0] s_arlen;
   logic [2:0]    s_arsize;
   logic          s_arready;
   logic [DW-1:0] s_rdata;
   logic [1:0]    s_rresp;
   logic          s_rvalid, s_rlast, s_rready;
   logic [1:0]    grant;
   logic          busy, len_err;

   axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst),
      .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arburst(arburst[0]),
      .m0_arlen(arlen[0]), .m0_arsize(arsize[0]), .m0_arready(arready[0]),
      .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]),
      .m0_rlast(rlast[0]), .m0_rready(rready[0]),
      .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arburst(arburst[1]),
      .m1_arlen(arlen[1]), .m1_arsize(arsize[1]), .m1_arready(arready[1]),
      .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]),
      .m1_rlast(rlast[1]), .m1_rready(rready[1]),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arburst(s_arburst),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
      .s_rlast(s_rlast), .s_rready(s_rready),
      .grant(grant), .busy(busy), .len_err(len_err)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- stimulus agent (masters + slave) ----------------
   bit       rand_on = 1'b0;
   bit [1:0] rready_knob = 2'b11;
   int       slave_delta = 0;
   int       s_left = 0, s_beat = 0, s_burst = 0;

   initial begin : agent
      bit            ar_hs_s, beat_s;
      bit [1:0]      macc_s;
      logic [LW-1:0] hs_len;
      int            n, dd;
      forever begin
         @(negedge clk);
         ar_hs_s = s_arvalid & s_arready;
         beat_s  = s_rvalid & s_rready;
         macc_s  = arvalid & arready;
         hs_len  = s_arlen;
         @(posedge clk);
         #1;
         if (!rst) begin
            arvalid   = 2'b00;
            s_left    = 0;
            s_rvalid  = 1'b0;
            s_rlast   = 1'b0;
            s_arready = 1'b0;
            continue;
         end
         for (int m = 0; m < 2; m++) begin
            if (macc_s[m]) arvalid[m] = 1'b0;
            else if (rand_on && arvalid[m] && $urandom_range(0, 99) < 4) arvalid[m] = 1'b0;
            if (rand_on && !arvalid[m] && $urandom_range(0, 99) < 25) begin
               araddr[m]  = $urandom;
               arlen[m]   = LW'($urandom_range(0, 7));
               arburst[m] = 2'($urandom_range(0, 3));
               arsize[m]  = 3'($urandom_range(0, 7));
               arvalid[m] = 1'b1;
            end
            rready[m] = rand_on ? ($urandom_range(0, 99) < 70) : rready_knob[m];
         end
         if (ar_hs_s) begin
            dd = rand_on ? (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) - 2 : 0)
                         : slave_delta;
            n = int'(hs_len) + 1 + dd;
            if (n < 1) n = 1;
            s_left = n;
            s_beat = 0;
         end
         if (beat_s) begin
            s_left--;
            s_beat++;
            if (s_left == 0) s_burst++;
         end
         if (s_left > 0) begin
            if (!s_rvalid || beat_s) s_rvalid = rand_on ? ($urandom_range(0, 99) < 70) : 1'b1;
         end else begin
            s_rvalid = 1'b0;
         end
         s_rdata   = {32'(s_burst), 32'(s_beat + 1)};
         s_rresp   = 2'(s_beat ^ s_burst);
         s_rlast   = (s_left == 1);
         s_arready = rand_on ? ($urandom_range(0, 99) < 70) : 1'b1;
      end
   end

   // ---------------- transaction-level reference model ----------------
   // own: current owner (-1 idle); in_ar: waiting for the address handshake;
   // beats: beats delivered so far in this burst; need: its arlen.
   int  own = -1, prev = 1, beats = 0, need = 0;
   bit  in_ar = 1'b0, err = 1'b0;
   logic [1:0]         e_g, e_arr, e_rv, e_rl;
   logic [1:0][1:0]    e_rr;
   logic [1:0][DW-1:0] e_rd;
   logic [45:0]        e_ar;
   logic               e_srr;

   initial begin : compare
      int o;
      bit ar, rd;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("rst_status", {grant, busy, len_err}, '0);
            check("rst_s_chan", {s_araddr, s_arburst, s_arlen, s_arsize, s_arvalid, s_rready}, '0);
            check("rst_m_ctl", {arready, rvalid, rlast, rresp}, '0);
            check("rst_m_data", rdata, '0);
         end else begin
            o  = (own < 0) ? 0 : own;
            ar = (own >= 0) && in_ar;
            rd = (own >= 0) && !in_ar;
            e_g = (own < 0) ? 2'b00 : (own == 0 ? 2'b01 : 2'b10);
            e_ar = ar ? {araddr[o], arburst[o], arlen[o], arsize[o], arvalid[o]} : '0;
            e_arr = '0; e_rv = '0; e_rl = '0; e_rr = '0; e_rd = '0;
            if (ar) e_arr[o] = s_arready;
            e_srr = rd ? rready[o] : 1'b0;
            if (rd) begin
               e_rv[o] = s_rvalid;
               e_rl[o] = s_rlast;
               e_rr[o] = s_rresp;
               e_rd[o] = s_rdata;
            end
            check("status", {grant, busy, len_err}, {e_g, own >= 0, err});
            check("s_ar", {s_araddr, s_arburst, s_arlen, s_arsize, s_arvalid}, e_ar);
            check("m_arready", arready, e_arr);
            check("s_rready", s_rready, e_srr);
            check("m0_r", {rvalid[0], rlast[0], rresp[0], rdata[0]}, {e_rv[0], e_rl[0], e_rr[0], e_rd[0]});
            check("m1_r", {rvalid[1], rlast[1], rresp[1], rdata[1]}, {e_rv[1], e_rl[1], e_rr[1], e_rd[1]});
         end
         @(posedge clk);
         if (!rst) begin
            own = -1; prev = 1; beats = 0; need = 0; in_ar = 1'b0; err = 1'b0;
         end else if (own < 0) begin
            if (arvalid != 2'b00) begin
               own   = (arvalid == 2'b11) ? 1 - prev : (arvalid[0] ? 0 : 1);
               in_ar = 1'b1;
            end
         end else if (in_ar) begin
            if (arvalid[own] && s_arready) begin
               need  = int'(arlen[own]);
               beats = 0;
               in_ar = 1'b0;
            end
         end else if (s_rvalid && rready[own]) begin
            if (s_rlast) begin
               if (beats != need) err = 1'b1;
               prev = own;
               own  = -1;
            end else begin
               if (beats == need) err = 1'b1;
               if (beats < 255) beats++;
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   bit other_rv = 1'b0;

   task automatic issue(input int m, input logic [AW-1:0] a, input logic [LW-1:0] l);
      araddr[m]  = a;
      arlen[m]   = l;
      arburst[m] = AXI_BURST_INCR;
      arsize[m]  = 3'd3;
      arvalid[m] = 1'b1;
   endtask

   task automatic wait_beat(input int m, output logic [DW-1:0] d, output logic l);
      bit got = 1'b0;
      d = '0;
      l = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (rvalid[1-m]) other_rv = 1'b1;
         if (rvalid[m] && rready[m]) begin
            got = 1'b1;
            d   = rdata[m];
            l   = rlast[m];
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL beat_timeout m%0d: no beat within 200 cycles, expected one", m);
      end
   endtask

   task automatic wait_grant(output int gcyc);
      bit got = 1'b0;
      gcyc = -1;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (grant != 2'b00) begin
            got  = 1'b1;
            gcyc = cyc;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL grant_timeout: grant still 00 after 50 cycles, expected nonzero");
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
   endtask

   task automatic drain(input int m, input int n);
      logic [DW-1:0] d;
      logic          l;
      for (int i = 0; i < n; i++) wait_beat(m, d, l);
   endtask

   // ---------------- directed scenarios + random phase ----------------
   initial begin : main
      logic [DW-1:0] d;
      logic          l;
      int            cl, cg;
      rst = 1'b0;
      araddr = '0; arvalid = '0; arburst = '0; arlen = '0; arsize = '0; rready = 2'b11;
      s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0; s_rlast = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_outputs", {grant, busy, len_err, s_arvalid, s_rready, arready, rvalid, rlast}, '0);
      #1 rst = 1'b1;

      // single request from m0
      @(posedge clk); #2 issue(0, 32'h8000_0040, 8'd7);
      @(posedge clk); #3;
      check("t1_grant", grant, 2'b01);
      check("t1_araddr", s_araddr, 32'h8000_0040);
      check("t1_s_arvalid", s_arvalid, 1'b1);
      other_rv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_beat(0, d, l);
         check("t1_data", d, 64'(i + 1));
         check("t1_rlast", l, (i == 7));
      end
      @(posedge clk); #3;
      check("t1_idle", {grant, busy, len_err}, 4'b0000);
      check("t1_m1_rvalid_quiet", other_rv, 1'b0);

      // simultaneous requests after reset, then alternating ties
      do_reset();
      @(posedge clk); #2;
      issue(0, 32'h0000_1000, 8'd3);
      issue(1, 32'h0000_2000, 8'd3);
      @(posedge clk); #3;
      check("t2_first_grant", grant, 2'b01);
      for (int i = 0; i < 4; i++) wait_beat(0, d, l);
      check("t2_m0_rlast", l, 1'b1);
      cl = cyc;
      @(posedge clk); #2 issue(0, 32'h0000_3000, 8'd3);
      wait_grant(cg);
      check("t2_second_grant", grant, 2'b10);
      check("t2_second_grant_cycle", cg - cl, 2);
      for (int i = 0; i < 4; i++) wait_beat(1, d, l);
      check("t2_m1_rlast", l, 1'b1);
      cl = cyc;
      @(posedge clk); #2 issue(1, 32'h0000_4000, 8'd3);
      wait_grant(cg);
      check("t2_third_grant", grant, 2'b01);
      check("t2_third_grant_cycle", cg - cl, 2);
      drain(0, 4);
      wait_grant(cg);
      check("t2_fourth_grant", grant, 2'b10);
      drain(1, 4);

      // back-pressure on m1
      @(posedge clk); #2 issue(1, 32'h0000_5000, 8'd7);
      for (int i = 0; i < 3; i++) begin
         wait_beat(1, d, l);
         check("t4_data_pre", d[31:0], 32'(i + 1));
      end
      @(posedge clk);
      rready_knob[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t4_s_rready_low", s_rready, 1'b0);
         check("t4_beat_held", {rvalid[1], rdata[1][31:0]}, {1'b1, 32'd4});
      end
      @(posedge clk);
      rready_knob[1] = 1'b1;
      for (int i = 3; i < 8; i++) begin
         wait_beat(1, d, l);
         check("t4_data_post", d[31:0], 32'(i + 1));
         check("t4_rlast", l, (i == 7));
      end
      @(posedge clk); #3;
      check("t4_no_err", {len_err, busy}, 2'b00);

      // short burst: rlast on beat 5 of 8
      do_reset();
      slave_delta = -3;
      @(posedge clk); #2 issue(0, 32'h0000_6000, 8'd7);
      for (int i = 0; i < 5; i++) begin
         wait_beat(0, d, l);
         check("t5a_err_before", len_err, 1'b0);
         check("t5a_rlast", l, (i == 4));
      end
      @(posedge clk); #3;
      check("t5a_after", {len_err, busy, grant}, 4'b1000);

      // long burst: 9 beats for arlen 7
      do_reset();
      slave_delta = 1;
      @(posedge clk); #2 issue(0, 32'h0000_7000, 8'd7);
      for (int i = 0; i < 9; i++) begin
         wait_beat(0, d, l);
         check("t5b_err", len_err, (i == 8));
         check("t5b_rlast", l, (i == 8));
      end
      check("t5b_busy_beat9", busy, 1'b1);
      @(posedge clk); #3;
      check("t5b_after", {len_err, busy, grant}, 4'b1000);
      slave_delta = 0;

      // asynchronous reset in the middle of a burst
      do_reset();
      @(posedge clk); #2 issue(0, 32'h0000_8000, 8'd7);
      for (int i = 0; i < 3; i++) wait_beat(0, d, l);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      check("t6_async_ctl", {grant, busy, len_err, s_arvalid, s_rready, arready, rvalid, rlast}, '0);
      check("t6_async_data", {s_araddr, rdata[0][31:0]}, '0);
      @(posedge clk); #3 rst = 1'b1;
      @(posedge clk); #2 issue(0, 32'h0000_9000, 8'd2);
      @(posedge clk); #3;
      check("t6_regrant", grant, 2'b01);
      for (int i = 0; i < 3; i++) begin
         wait_beat(0, d, l);
         check("t6_rlast", l, (i == 2));
      end

      // randomized traffic, with a reset between segments
      for (int seg = 0; seg < 4; seg++) begin
         do_reset();
         rand_on = 1'b1;
         repeat (1000) @(posedge clk);
      end
      rand_on = 1'b0;
      do_reset();
      repeat (5) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
